spd_mod_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one spd_mod_sub_stgb modular unit (mod-mul reduction,
//  mod-add, mod-sub) between NREQ requesters, e.g. the point-add and point-double engines.

---
 rtl/spd_mod_arb_if.sv | 36 +++
 rtl/spd_mod_arb.sv | 168 ++++++++++++++++
 tb/tb_spd_mod_arb.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spd_mod_arb_if.sv
// Request/response and modular-unit bundle for spd_mod_arb.
// master = arbiter side, slave = requesters plus the shared modular unit.
interface spd_mod_arb_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]     req_vld;
  logic [NREQ-1:0]     req_rdy;
  logic [2*NREQ-1:0]   req_op;
  logic [512*NREQ-1:0] req_a;
  logic [256*NREQ-1:0] req_mod;
  logic                rsp_vld;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;
  logic [255:0]        rsp_data;
  logic                mod_vld_o;
  logic [1:0]          op_sel_o;
  logic [255:0]        op_mod_num_o;
  logic [511:0]        p512_o;
  logic                mod_fin_i;
  logic [255:0]        mul_res_i;
  logic [255:0]        addsub_res_i;
  logic                busy;

  modport master (
    input  req_vld, req_op, req_a, req_mod, mod_fin_i, mul_res_i, addsub_res_i,
    output req_rdy, rsp_vld, rsp_id, rsp_err, rsp_data,
           mod_vld_o, op_sel_o, op_mod_num_o, p512_o, busy
  );

  modport slave (
    output req_vld, req_op, req_a, req_mod, mod_fin_i, mul_res_i, addsub_res_i,
    input  req_rdy, rsp_vld, rsp_id, rsp_err, rsp_data,
           mod_vld_o, op_sel_o, op_mod_num_o, p512_o, busy
  );
endinterface

// File: rtl/spd_mod_arb.sv
// Round-robin sequencer sharing one modular mul/add/sub unit between NREQ requesters.
// One operation in flight; a DONE cycle with mod_vld low separates operations.
module spd_mod_arb #(
  parameter int NREQ    = 2,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  spd_mod_arb_if.master bus
);
  localparam int         CW     = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [1:0]      op_q, op_d;
  logic [511:0]    p512_q, p512_d;
  logic [255:0]    mod_q, mod_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mod_vld_q, mod_vld_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic            rsp_err_q, rsp_err_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [255:0]    rsp_data_q, rsp_data_d;

  logic [1:0]      op_arr  [NREQ];
  logic [511:0]    a_arr   [NREQ];
  logic [255:0]    mod_arr [NREQ];
  logic [IDW-1:0]  win;
  logic            found;
  logic            grant;
  logic [NREQ-1:0] rdy;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign op_arr[gi]  = bus.req_op[2*gi +: 2];
      assign a_arr[gi]   = bus.req_a[512*gi +: 512];
      assign mod_arr[gi] = bus.req_mod[256*gi +: 256];
    end
  endgenerate

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_vld[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign grant = (state_q == IDLE) && found;

  always_comb begin
    rdy = '0;
    if (grant) rdy[win] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    p512_d     = p512_q;
    mod_d      = mod_q;
    cnt_d      = cnt_q;
    mod_vld_d  = mod_vld_q;
    rsp_vld_d  = 1'b0;
    rsp_err_d  = rsp_err_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          ptr_d  = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
          id_d   = win;
          op_d   = op_arr[win];
          p512_d = a_arr[win];
          mod_d  = mod_arr[win];
          cnt_d  = '0;
          if (op_arr[win] == OP_ILL) begin
            state_d    = DONE;
            rsp_vld_d  = 1'b1;
            rsp_id_d   = win;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d   = RUN;
            mod_vld_d = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // A fin arriving on the last allowed cycle still beats the timeout.
        if (bus.mod_fin_i) begin
          state_d    = DONE;
          mod_vld_d  = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_id_d   = id_q;
          rsp_err_d  = 1'b0;
          rsp_data_d = (op_q == OP_MUL) ? bus.mul_res_i : bus.addsub_res_i;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = DONE;
          mod_vld_d  = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_id_d   = id_q;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      op_q       <= '0;
      p512_q     <= '0;
      mod_q      <= '0;
      cnt_q      <= '0;
      mod_vld_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      p512_q     <= p512_d;
      mod_q      <= mod_d;
      cnt_q      <= cnt_d;
      mod_vld_q  <= mod_vld_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.req_rdy      = rdy;
  assign bus.rsp_vld      = rsp_vld_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.mod_vld_o    = mod_vld_q;
  assign bus.op_sel_o     = op_q;
  assign bus.op_mod_num_o = mod_q;
  assign bus.p512_o       = p512_q;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_spd_mod_arb.sv
// Bench for spd_mod_arb: behavioural modular-unit stub plus a spec-level model of
// grant order, latency and results; directed cases followed by random traffic.
module tb_spd_mod_arb;
  localparam int TO = 15;
  localparam logic [255:0] P_SM2 =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spd_mod_arb_if #(.NREQ(2), .IDW(1)) bus ();

  spd_mod_arb #(.NREQ(2), .IDW(1), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int stub_mode = 0;   // 0 normal, 1 never fin, 2 fin on last allowed cycle, 3 fin stuck high
  int run_cnt = 0;
  int rr = 0;

  function automatic logic [255:0] f_mul(input logic [511:0] x);
    logic [511:0] r;
    r = x % {256'b0, P_SM2};
    return r[255:0];
  endfunction

  function automatic logic [255:0] f_add(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] m);
    logic [257:0] s;
    if (m == '0) return '0;
    s = {2'b0, a} + {2'b0, b};
    s = s % {2'b0, m};
    return s[255:0];
  endfunction

  function automatic logic [255:0] f_sub(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] m);
    logic [257:0] s;
    if (m == '0) return '0;
    s = {2'b0, a % m} + {2'b0, m} - {2'b0, b % m};
    s = s % {2'b0, m};
    return s[255:0];
  endfunction

  function automatic logic [255:0] ref_result(input logic [1:0] op, input logic [511:0] a,
                                               input logic [255:0] m);
    case (op)
      2'b00:   return f_mul(a);
      2'b01:   return f_add(a[511:256], a[255:0], m);
      2'b10:   return f_sub(a[511:256], a[255:0], m);
      default: return '0;
    endcase
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Modular-unit stub: counts cycles of mod_vld high and raises fin at the unit's latency.
  always @(posedge clk) begin
    if (!bus.mod_vld_o) run_cnt <= 0;
    else                run_cnt <= run_cnt + 1;
  end

  assign bus.mod_fin_i = (stub_mode == 3) ? 1'b1 :
                         (stub_mode == 1) ? 1'b0 :
                         (stub_mode == 2) ? (bus.mod_vld_o && run_cnt == TO - 1) :
                         (bus.mod_vld_o && run_cnt == ((bus.op_sel_o == 2'b00) ? 3 : 0));
  assign bus.mul_res_i    = f_mul(bus.p512_o);
  assign bus.addsub_res_i = (bus.op_sel_o == 2'b01) ?
                              f_add(bus.p512_o[511:256], bus.p512_o[255:0], bus.op_mod_num_o) :
                            (bus.op_sel_o == 2'b10) ?
                              f_sub(bus.p512_o[511:256], bus.p512_o[255:0], bus.op_mod_num_o) :
                            256'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [511:0] a,
                         input logic [255:0] m);
    bus.req_op[2*id +: 2]    = op;
    bus.req_a[512*id +: 512] = a;
    bus.req_mod[256*id +: 256] = m;
    bus.req_vld[id]          = 1'b1;
  endtask

  function automatic int exp_winner(input logic [1:0] pend);
    int w;
    w = -1;
    for (int k = 0; k < 2; k++) begin
      int j;
      j = (rr + k) % 2;
      if (w < 0 && pend[j]) w = j;
    end
    return w;
  endfunction

  // Called in the handshake cycle (c0) after the grant was checked; returns in the next IDLE cycle.
  task automatic finish_txn(input int id, input logic [1:0] op, input logic [511:0] a,
                            input logic [255:0] m, input int mode, input bit keep,
                            input string tag);
    bit          ee;
    logic [255:0] ed;
    int          el;
    int          lat;
    bit          saw_mv;
    ee  = (op == 2'b11) || (mode == 1);
    ed  = ee ? 256'b0 : ref_result(op, a, m);
    el  = (op == 2'b11) ? 1 : (mode != 0) ? TO + 1 : (op == 2'b00) ? 5 : 2;
    lat = 0;
    saw_mv = 1'b0;
    stub_mode = mode;
    rr = (id + 1) % 2;
    tick();
    if (!keep) bus.req_vld[id] = 1'b0;
    for (int n = 1; n <= TO + 4; n++) begin
      if (bus.mod_vld_o) saw_mv = 1'b1;
      if (n == 1 && op != 2'b11) begin
        chk({tag, "_mod_vld"}, bus.mod_vld_o, 1);
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_op_sel"}, bus.op_sel_o, op);
        chk({tag, "_p512"}, bus.p512_o, a);
        chk({tag, "_mod"}, bus.op_mod_num_o, m);
      end
      if (bus.rsp_vld) begin
        lat = n;
        break;
      end
      tick();
    end
    chk({tag, "_latency"}, lat, el);
    chk({tag, "_rsp_id"}, bus.rsp_id, id);
    chk({tag, "_rsp_err"}, bus.rsp_err, ee);
    chk({tag, "_rsp_data"}, bus.rsp_data, ed);
    chk({tag, "_gap_mod_vld"}, bus.mod_vld_o, 0);
    chk({tag, "_rdy_in_done"}, bus.req_rdy, 0);
    if (op == 2'b11) chk({tag, "_ill_no_mod_vld"}, saw_mv, 0);
    tick();
    chk({tag, "_rsp_pulse"}, bus.rsp_vld, 0);
    chk({tag, "_rsp_hold"}, bus.rsp_data, ed);
    $display("txn %s id=%0d op=%0d lat=%0d err=%0b data=%h", tag, id, op, lat, bus.rsp_err,
             bus.rsp_data);
    stub_mode = 0;
  endtask

  task automatic issue(input int id, input logic [1:0] op, input logic [511:0] a,
                       input logic [255:0] m, input int mode, input string tag);
    logic [1:0] er;
    set_req(id, op, a, m);
    #1;
    er = '0;
    er[id] = 1'b1;
    chk({tag, "_rdy"}, bus.req_rdy, er);
    finish_txn(id, op, a, m, mode, 1'b0, tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] a;
    logic [511:0] a1;
    logic [255:0] m;
    logic [1:0]   er;
    logic [1:0]   pend;
    logic [1:0]   r_op  [2];
    logic [511:0] r_a   [2];
    logic [255:0] r_m   [2];
    int           w;

    rst = 1'b1;
    bus.req_vld = '0;
    bus.req_op  = '0;
    bus.req_a   = '0;
    bus.req_mod = '0;
    repeat (3) tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_rsp_vld", bus.rsp_vld, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_id", bus.rsp_id, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_mod_vld", bus.mod_vld_o, 0);
    chk("reset_op_sel", bus.op_sel_o, 0);
    chk("reset_p512", bus.p512_o, 0);
    chk("reset_mod_num", bus.op_mod_num_o, 0);
    chk("reset_rdy", bus.req_rdy, 0);
    rst = 1'b0;
    tick();

    // fin outside RUN must not start or finish anything
    stub_mode = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_fin_rsp", bus.rsp_vld, 0);
      chk("idle_fin_busy", bus.busy, 0);
    end
    stub_mode = 0;

    a = {P_SM2 - 256'd1, 256'd2};
    issue(0, 2'b01, a, P_SM2, 0, "add_wrap");
    chk("add_wrap_const", bus.rsp_data, 256'd1);

    a = {256'd1, 256'd2};
    issue(0, 2'b10, a, P_SM2, 0, "sub_borrow");
    chk("sub_borrow_const", bus.rsp_data,
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFE);

    a = '0;
    a[256] = 1'b1;
    issue(0, 2'b00, a, P_SM2, 0, "mul_2p256");
    chk("mul_2p256_const", bus.rsp_data,
        256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001);

    a = {256'd5, 256'd7};
    issue(0, 2'b11, a, P_SM2, 0, "illegal");
    issue(0, 2'b01, a, P_SM2, 1, "timeout");
    issue(0, 2'b10, a, P_SM2, 2, "fin_at_limit");

    // both requesters continuously valid: grants alternate with a 3-cycle issue interval
    a  = {256'd11, 256'd22};
    a1 = {256'd33, 256'd44};
    set_req(0, 2'b01, a, P_SM2);
    set_req(1, 2'b01, a1, P_SM2);
    #1;
    for (int g = 0; g < 6; g++) begin
      w = exp_winner(2'b11);
      er = '0;
      er[w] = 1'b1;
      chk("alt_grant", bus.req_rdy, er);
      finish_txn(w, 2'b01, (w == 0) ? a : a1, P_SM2, 0, 1'b1, "alt");
    end
    bus.req_vld = '0;
    tick();

    // reset in the 2nd RUN cycle of a mul
    a = rand256() * 256'd3;
    set_req(0, 2'b00, a, P_SM2);
    #1;
    chk("rst_mul_rdy", bus.req_rdy, 2'b01);
    tick();
    bus.req_vld[0] = 1'b0;
    tick();
    chk("rst_mul_running", bus.mod_vld_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr = 0;
    chk("rst_mod_vld", bus.mod_vld_o, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_op_sel", bus.op_sel_o, 0);
    chk("rst_p512", bus.p512_o, 0);
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_rsp", bus.rsp_vld, 0);
      tick();
    end
    a = {256'd100, 256'd23};
    issue(1, 2'b01, a, P_SM2, 0, "after_rst");

    // random traffic with requests held until granted
    pend = '0;
    for (int t = 0; t < 30; t++) begin
      for (int j = 0; j < 2; j++) begin
        if (!pend[j] && ($urandom_range(0, 1) == 1 || (pend == '0 && j == 1))) begin
          r_m[j]  = rand256();
          r_m[j][255] = 1'b1;
          r_op[j] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          if (r_op[j] == 2'b00) r_a[j] = {rand256(), rand256()};
          else r_a[j] = {rand256() % r_m[j], rand256() % r_m[j]};
          set_req(j, r_op[j], r_a[j], r_m[j]);
          pend[j] = 1'b1;
        end
      end
      #1;
      w = exp_winner(pend);
      er = '0;
      er[w] = 1'b1;
      chk("rand_grant", bus.req_rdy, er);
      finish_txn(w, r_op[w], r_a[w], r_m[w], 0, 1'b0, "rand");
      pend[w] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
